// File: rtl/stack_pkg.sv
// Shared encodings and default widths for the stack controller and its bench.
package stack_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_POP2  = 2'b10,
    OP_PEEK2 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command, response and MEMORIA bus bundle; master is the controller side.
interface stack_ctrl_if #(
  parameter int DATA_W = stack_pkg::DATA_W_DEF,
  parameter int ADDR_W = stack_pkg::ADDR_W_DEF
);
  import stack_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_d1;
  logic [DATA_W-1:0] rsp_d2;
  logic              rsp_err;
  logic [ADDR_W:0]   count;

  logic [DATA_W-1:0] mem_x;
  logic [ADDR_W-1:0] mem_ind1;
  logic [ADDR_W-1:0] mem_ind2;
  logic              mem_beta;
  logic [DATA_W-1:0] mem_out1;
  logic [DATA_W-1:0] mem_out2;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, mem_out1, mem_out2,
    output cmd_ready, rsp_valid, rsp_d1, rsp_d2, rsp_err, count,
           mem_x, mem_ind1, mem_ind2, mem_beta
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, mem_out1, mem_out2,
    input  cmd_ready, rsp_valid, rsp_d1, rsp_d2, rsp_err, count,
           mem_x, mem_ind1, mem_ind2, mem_beta
  );

endinterface

// File: rtl/stack_ctrl.sv
// Push/pop stack controller driving MEMORIA: one write or dual read per command,
// with stack pointer tracking and overflow/underflow reporting.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic         clock,
  input  logic         reset,
  stack_ctrl_if.master bus
);

  // state  | meaning
  // S_IDLE | cmd_ready high, waiting for a command
  // S_EXEC | one memory cycle: write for PUSH, dual read otherwise
  // S_RESP | rsp_valid high, response held until rsp_ready
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TWO_C   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e            state_q;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   count_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_d1_q;
  logic [DATA_W-1:0] rsp_d2_q;
  logic [DATA_W-1:0] mem_x_q;
  logic [ADDR_W-1:0] mem_ind1_q;
  logic [ADDR_W-1:0] mem_ind2_q;
  logic              mem_beta_q;

  logic [ADDR_W:0]   cnt_m1;
  logic [ADDR_W:0]   cnt_m2;
  logic              err;

  assign cnt_m1 = count_q - ONE_C;
  assign cnt_m2 = count_q - TWO_C;

  always_comb begin
    err = 1'b0;
    case (bus.cmd_op)
      OP_PUSH: err = (count_q == DEPTH_C);
      OP_POP:  err = (count_q == '0);
      default: err = (count_q < TWO_C);
    endcase
  end

  // Memory bus is registered at accept so the write/read lands in the EXEC cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_d1_q    <= '0;
      rsp_d2_q    <= '0;
      mem_x_q     <= '0;
      mem_ind1_q  <= '0;
      mem_ind2_q  <= '0;
      mem_beta_q  <= 1'b0;
    end else begin
      mem_beta_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            data_q      <= bus.cmd_data;
            cmd_ready_q <= 1'b0;
            if (err) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              rsp_err_q <= 1'b0;
              state_q   <= S_EXEC;
              case (bus.cmd_op)
                OP_PUSH: begin
                  mem_ind1_q <= count_q[ADDR_W-1:0];
                  mem_x_q    <= bus.cmd_data;
                  mem_beta_q <= 1'b1;
                end
                OP_POP: mem_ind1_q <= cnt_m1[ADDR_W-1:0];
                default: begin
                  mem_ind1_q <= cnt_m1[ADDR_W-1:0];
                  mem_ind2_q <= cnt_m2[ADDR_W-1:0];
                end
              endcase
            end
          end
        end
        S_EXEC: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          case (op_q)
            OP_PUSH: begin
              rsp_d1_q <= data_q;
              count_q  <= count_q + ONE_C;
            end
            OP_POP: begin
              rsp_d1_q <= bus.mem_out1;
              count_q  <= cnt_m1;
            end
            OP_POP2: begin
              rsp_d1_q <= bus.mem_out1;
              rsp_d2_q <= bus.mem_out2;
              count_q  <= cnt_m2;
            end
            default: begin
              rsp_d1_q <= bus.mem_out1;
              rsp_d2_q <= bus.mem_out2;
            end
          endcase
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_d1    = rsp_d1_q;
  assign bus.rsp_d2    = rsp_d2_q;
  assign bus.count     = count_q;
  assign bus.mem_x     = mem_x_q;
  assign bus.mem_ind1  = mem_ind1_q;
  assign bus.mem_ind2  = mem_ind2_q;
  assign bus.mem_beta  = mem_beta_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with a behavioural MEMORIA responder.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          err;
    logic          chk_d2;
    int            cnt;
  } exp_t;

  logic clock;
  logic reset;
  stack_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clock) if (bus.mem_beta) mem[bus.mem_ind1] <= bus.mem_x;
  assign bus.mem_out1 = mem[bus.mem_ind1];
  assign bus.mem_out2 = mem[bus.mem_ind2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int beta_seen = 0;
  exp_t exp_q[$];
  logic [DW-1:0] mdl[$];

  always @(negedge clock) if (bus.mem_beta) beta_seen = beta_seen + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic run_cmd(input op_e op, input logic [DW-1:0] data, input int hold);
    exp_t e;
    exp_t g;
    int sz;
    int lat;
    int w;
    logic [AW-1:0] xi1;
    logic [AW-1:0] xi2;
    logic [DW-1:0] xx;
    sz = mdl.size();
    e.err = 1'b0; e.chk_d2 = 1'b0; e.d1 = '0; e.d2 = '0;
    case (op)
      OP_PUSH: if (sz == DEPTH) e.err = 1'b1;
               else begin e.d1 = data; mdl.push_back(data); end
      OP_POP:  if (sz == 0) e.err = 1'b1;
               else e.d1 = mdl.pop_back();
      default: if (sz < 2) e.err = 1'b1;
               else begin
                 e.d1 = mdl[sz-1]; e.d2 = mdl[sz-2]; e.chk_d2 = 1'b1;
                 if (op == OP_POP2) begin void'(mdl.pop_back()); void'(mdl.pop_back()); end
               end
    endcase
    e.cnt = mdl.size();
    exp_q.push_back(e);

    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clock); w++; end
    chk("ready_wait", 64'(w < 20), 1);
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    beta_seen = 0;

    @(negedge clock);
    lat = 1;
    xi1 = bus.mem_ind1; xi2 = bus.mem_ind2; xx = bus.mem_x;
    while (!bus.rsp_valid && lat < 8) begin @(negedge clock); lat++; end
    chk("latency", lat, e.err ? 1 : 2);

    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
    else begin
      g = exp_q.pop_front();
      chk("rsp_err", bus.rsp_err, g.err);
      if (!g.err) chk("rsp_d1", bus.rsp_d1, g.d1);
      if (g.chk_d2) chk("rsp_d2", bus.rsp_d2, g.d2);
      chk("count", bus.count, g.cnt);
      if (!g.err) begin
        case (op)
          OP_PUSH: begin chk("wr_ind1", xi1, sz); chk("wr_x", xx, data); end
          OP_POP:  chk("rd_ind1", xi1, sz - 1);
          default: begin chk("rd_ind1", xi1, sz - 1); chk("rd_ind2", xi2, sz - 2); end
        endcase
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_d1", bus.rsp_d1, g.d1);
        chk("hold_ready", bus.cmd_ready, 0);
      end
    end
    chk("beta_cnt", beta_seen, (op == OP_PUSH && !e.err) ? 1 : 0);
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_PUSH; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    #12;
    chk("rst_beta", bus.mem_beta, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_ind1", bus.mem_ind1, 0);
    chk("rst_d1", bus.rsp_d1, 0);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", bus.cmd_ready, 1);

    run_cmd(OP_PUSH, 32'd42, 0);
    run_cmd(OP_PUSH, 32'd128, 0);
    run_cmd(OP_POP2, 32'd0, 0);
    run_cmd(OP_POP, 32'd0, 0);
    run_cmd(OP_PEEK2, 32'd0, 0);
    run_cmd(OP_PUSH, 32'd256, 10);
    run_cmd(OP_POP, 32'd0, 0);

    for (int i = 0; i < DEPTH; i++) run_cmd(OP_PUSH, 32'(i), 0);
    run_cmd(OP_PUSH, 32'd1024, 0);
    run_cmd(OP_PEEK2, 32'd0, 0);
    run_cmd(OP_POP, 32'd0, 0);
    run_cmd(OP_POP2, 32'd0, 0);

    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_PUSH; bus.cmd_data = 32'd7;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clock);
    chk("exec_beta", bus.mem_beta, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_beta", bus.mem_beta, 0);
    chk("async_count", bus.count, 0);
    chk("async_valid", bus.rsp_valid, 0);
    @(negedge clock) reset = 1'b0;
    mdl.delete();
    exp_q.delete();
    run_cmd(OP_POP, 32'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
